// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem transaction, results parked in a small buffer for decode.
// Define IF_SKID_BUF_EN for a 2-entry FIFO; otherwise a single holding register is used.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef FLOW_WIDTH
`define FLOW_WIDTH 2
`endif
`ifndef FLOW_WORK
`define FLOW_WORK 2'b01
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'b10
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'b11
`endif

module if_fetch #(
    parameter logic [`CPU_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [`FLOW_WIDTH-1:0] flow_if_i,
    input  logic [`CPU_WIDTH-1:0]  pc_i,
    output logic                   pc_ack_o,
    output logic                   imem_req_o,
    output logic [`CPU_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [`CPU_WIDTH-1:0]  imem_rdata_i,
    input  logic                   id_ready_i,
    output logic                   inst_valid_o,
    output logic [`CPU_WIDTH-1:0]  inst_o,
    output logic [`CPU_WIDTH-1:0]  inst_pc_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

`ifdef IF_SKID_BUF_EN
    localparam logic [1:0] DEPTH = 2'd2;
`else
    localparam logic [1:0] DEPTH = 2'd1;
`endif

    state_e                  state_q, state_d;
    logic [`CPU_WIDTH-1:0]   tag_q, tag_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    work, refresh, push, pop;
    logic [`CPU_WIDTH-1:0]   head_inst, head_pc;

    // Anything that is neither WORK nor STOP behaves as a refresh.
    assign work    = (flow_if_i == `FLOW_WORK);
    assign refresh = !work && (flow_if_i != `FLOW_STOP);
    assign push    = (state_q == WAIT) && imem_rvalid_i && !refresh;
    assign pop     = inst_valid_o && id_ready_i && !refresh;

    always_comb begin
        cnt_d = cnt_q;
        if (refresh) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef IF_SKID_BUF_EN
    logic [`CPU_WIDTH-1:0] buf_pc_q [2];
    logic [`CPU_WIDTH-1:0] buf_pc_d [2];
    logic [`CPU_WIDTH-1:0] buf_inst_q [2];
    logic [`CPU_WIDTH-1:0] buf_inst_d [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    always_comb begin
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (refresh) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                buf_pc_d[wr_ptr_q]   = tag_q;
                buf_inst_d[wr_ptr_q] = imem_rdata_i;
                wr_ptr_d             = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_pc_q   <= '{default: '0};
            buf_inst_q <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
        end else begin
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign head_pc   = buf_pc_q[rd_ptr_q];
    assign head_inst = buf_inst_q[rd_ptr_q];
`else
    logic [`CPU_WIDTH-1:0] buf_pc_q, buf_pc_d, buf_inst_q, buf_inst_d;

    always_comb begin
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        if (push) begin
            buf_pc_d   = tag_q;
            buf_inst_d = imem_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
        end else begin
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign head_pc   = buf_pc_q;
    assign head_inst = buf_inst_q;
`endif

    // Only enter REQ with a free entry, so the single outstanding response always has a slot.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                if (work && (cnt_q < DEPTH)) state_d = REQ;
            end
            REQ: begin
                if (refresh) begin
                    state_d = IDLE;
                end else if (imem_gnt_i) begin
                    tag_d   = pc_i;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (refresh) begin
                    state_d = imem_rvalid_i ? IDLE : DROP;
                end else if (imem_rvalid_i) begin
                    state_d = (work && (cnt_d < DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req_o   = (state_q == REQ) && !refresh;
    assign imem_addr_o  = imem_req_o ? pc_i : '0;
    assign pc_ack_o     = imem_req_o && imem_gnt_i;
    assign inst_valid_o = (cnt_q != 2'd0);
    assign inst_o       = inst_valid_o ? head_inst : NOP_INST;
    assign inst_pc_o    = inst_valid_o ? head_pc : '0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a cycle vector table for the basic fetch, then scripted corner sequences;
// instructions written to the buffer are tracked in a queue and matched on each decode handshake.
`ifndef FLOW_WORK
`define FLOW_WORK 2'b01
`endif
`ifndef FLOW_STOP
`define FLOW_STOP 2'b10
`endif
`ifndef FLOW_REFRESH
`define FLOW_REFRESH 2'b11
`endif

module tb_if_fetch;
    localparam logic [1:0] FW = `FLOW_WORK;
    localparam logic [1:0] FS = `FLOW_STOP;
    localparam logic [1:0] FR = `FLOW_REFRESH;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  flow_if_i;
    logic [31:0] pc_i, imem_addr_o, imem_rdata_i, inst_o, inst_pc_o;
    logic        pc_ack_o, imem_req_o, imem_gnt_i, imem_rvalid_i, id_ready_i, inst_valid_o;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst_n(rst_n), .flow_if_i(flow_if_i), .pc_i(pc_i), .pc_ack_o(pc_ack_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .id_ready_i(id_ready_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]  flow;
        logic [31:0] pc, gnt, rv, rdata, idr, push, tag;
        logic [31:0] e_req, e_addr, e_ack, e_val, e_inst, e_ipc;
    } vec_t;
    vec_t vt[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic setin(input logic [1:0] f, input logic [31:0] p, input logic g, input logic r,
                         input logic [31:0] d, input logic i);
        flow_if_i = f; pc_i = p; imem_gnt_i = g; imem_rvalid_i = r; imem_rdata_i = d; id_ready_i = i;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic rq, input logic [31:0] ad, input logic ak,
                            input logic v, input logic [31:0] in, input logic [31:0] ip);
        chk({tag, "_req"},   32'(imem_req_o),   32'(rq));
        chk({tag, "_addr"},  imem_addr_o,       ad);
        chk({tag, "_ack"},   32'(pc_ack_o),     32'(ak));
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'(v));
        chk({tag, "_inst"},  inst_o,            in);
        chk({tag, "_ipc"},   inst_pc_o,         ip);
    endtask

    // Decode-side scoreboard: every accepted instruction must be the oldest one written.
    always @(negedge clk) begin
        sb_t e;
        if (rst_n && inst_valid_o && id_ready_i && (flow_if_i == FW || flow_if_i == FS)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual pc=%h inst=%h required none", inst_pc_o, inst_o);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", inst_pc_o, e.pc);
                chk("sb_inst", inst_o, e.inst);
            end
        end
    end

    initial begin
        //          flow pc     gnt rv rdata         idr push tag   | req addr   ack val inst          ipc
        vt[0]  = '{FW, 32'h00, 0, 0, 0,            1, 0, 0,      0, 0,      0, 0, NOP,          0};
        vt[1]  = '{FW, 32'h00, 0, 0, 0,            1, 0, 0,      1, 0,      0, 0, NOP,          0};
        vt[2]  = '{FW, 32'h00, 1, 0, 0,            1, 0, 0,      1, 0,      1, 0, NOP,          0};
        vt[3]  = '{FW, 32'h04, 0, 0, 0,            1, 0, 0,      0, 0,      0, 0, NOP,          0};
        vt[4]  = '{FS, 32'h04, 0, 1, 32'h00A00093, 1, 1, 0,      0, 0,      0, 0, NOP,          0};
        vt[5]  = '{FS, 32'h04, 0, 0, 0,            1, 0, 0,      0, 0,      0, 1, 32'h00A00093, 0};
        vt[6]  = '{FW, 32'h10, 0, 0, 0,            1, 0, 0,      0, 0,      0, 0, NOP,          0};
        vt[7]  = '{FW, 32'h10, 0, 0, 0,            1, 0, 0,      1, 32'h10, 0, 0, NOP,          0};
        vt[8]  = '{FW, 32'h10, 0, 0, 0,            1, 0, 0,      1, 32'h10, 0, 0, NOP,          0};
        vt[9]  = '{FW, 32'h10, 0, 0, 0,            1, 0, 0,      1, 32'h10, 0, 0, NOP,          0};
        vt[10] = '{FW, 32'h10, 1, 0, 0,            1, 0, 0,      1, 32'h10, 1, 0, NOP,          0};
        vt[11] = '{FS, 32'h14, 0, 1, 32'h11111111, 1, 1, 32'h10, 0, 0,      0, 0, NOP,          0};
        vt[12] = '{FS, 32'h14, 0, 0, 0,            1, 0, 0,      0, 0,      0, 1, 32'h11111111, 32'h10};
        vt[13] = '{FS, 32'h14, 0, 0, 0,            1, 0, 0,      0, 0,      0, 0, NOP,          0};

        // Reset with a live-looking request on the inputs.
        rst_n = 1'b0;
        setin(FW, 32'h44, 1'b1, 1'b0, 32'h0, 1'b1);
        #12;
        chk_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, NOP, 32'h0);
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            setin(vt[i].flow, vt[i].pc, vt[i].gnt[0], vt[i].rv[0], vt[i].rdata, vt[i].idr[0]);
            if (vt[i].push[0]) sb_q.push_back('{vt[i].tag, vt[i].rdata});
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vt[i].e_req[0], vt[i].e_addr, vt[i].e_ack[0],
                     vt[i].e_val[0], vt[i].e_inst, vt[i].e_ipc);
            step();
        end

        // Decode stall: buffer fills to capacity, then no further request.
        setin(FW, 32'h20, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("stall_c0_req", 32'(imem_req_o), 32'd0); step();
        setin(FW, 32'h20, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("stall_c1_addr", imem_addr_o, 32'h20); chk("stall_c1_ack", 32'(pc_ack_o), 32'd1); step();
        setin(FW, 32'h24, 1'b0, 1'b1, 32'hD1D1_0001, 1'b0);
        sb_q.push_back('{32'h20, 32'hD1D1_0001});
        @(negedge clk); chk("stall_c2_req", 32'(imem_req_o), 32'd0); step();
`ifdef IF_SKID_BUF_EN
        setin(FW, 32'h24, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("stall_c3_addr", imem_addr_o, 32'h24); chk("stall_c3_ack", 32'(pc_ack_o), 32'd1); step();
        setin(FW, 32'h28, 1'b0, 1'b1, 32'hD2D2_0002, 1'b0);
        sb_q.push_back('{32'h24, 32'hD2D2_0002});
        @(negedge clk); step();
`endif
        for (int k = 0; k < 3; k++) begin
            setin(FW, 32'h28, 1'b1, 1'b0, 32'h0, 1'b0);
            @(negedge clk);
            chk("stall_hold_req", 32'(imem_req_o), 32'd0);
            chk("stall_hold_ack", 32'(pc_ack_o), 32'd0);
            chk("stall_hold_valid", 32'(inst_valid_o), 32'd1);
            chk("stall_hold_head", inst_pc_o, 32'h20);
            step();
        end
        setin(FS, 32'h28, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); step();
`ifdef IF_SKID_BUF_EN
        @(negedge clk); step();
`endif
        @(negedge clk); chk("stall_drained", 32'(inst_valid_o), 32'd0); step();
        chk("stall_sb_empty", 32'(sb_q.size()), 32'd0);

        // Refresh in WAIT, response two cycles later must be dropped.
        setin(FW, 32'h30, 1'b0, 1'b0, 32'h0, 1'b1); step();
        setin(FW, 32'h30, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk); chk("rfs_ack", 32'(pc_ack_o), 32'd1); step();
        setin(FR, 32'h34, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); chk("rfs_req", 32'(imem_req_o), 32'd0); step();
        setin(FW, 32'h34, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); chk("drop_noreq", 32'(imem_req_o), 32'd0); step();
        setin(FW, 32'h34, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk); step();
        setin(FS, 32'h34, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); chk_outs("drop_done", 1'b0, 32'h0, 1'b0, 1'b0, NOP, 32'h0); step();

        // Refresh and rvalid together: data dropped, straight back to IDLE.
        setin(FW, 32'h38, 1'b0, 1'b0, 32'h0, 1'b1); step();
        setin(FW, 32'h38, 1'b1, 1'b0, 32'h0, 1'b1); step();
        setin(FR, 32'h3C, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1);
        @(negedge clk); chk("rfsrv_req", 32'(imem_req_o), 32'd0); step();
        setin(FW, 32'h3C, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); chk("rfsrv_valid", 32'(inst_valid_o), 32'd0); chk("rfsrv_idle", 32'(imem_req_o), 32'd0); step();
        @(negedge clk); chk("rfsrv_resume", 32'(imem_req_o), 32'd1); chk("rfsrv_addr", imem_addr_o, 32'h3C); step();
        setin(FR, 32'h3C, 1'b0, 1'b0, 32'h0, 1'b1); step();

        // STOP in IDLE: nothing issued even with gnt high; WORK resumes next cycle.
        for (int k = 0; k < 5; k++) begin
            setin(FS, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
            chk("stop_req", 32'(imem_req_o), 32'd0);
            chk("stop_ack", 32'(pc_ack_o), 32'd0);
            step();
        end
        setin(FW, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk("resume_c0_req", 32'(imem_req_o), 32'd0); step();
        setin(FW, 32'h40, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_outs("resume_c1", 1'b1, 32'h40, 1'b1, 1'b0, NOP, 32'h0); step();
        setin(FW, 32'h44, 1'b0, 1'b1, 32'h0000_0513, 1'b0);
        sb_q.push_back('{32'h40, 32'h0000_0513});
        @(negedge clk); step();
        // Unknown flow encoding flushes the held entry.
        setin(2'b00, 32'h44, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("unk_pre_valid", 32'(inst_valid_o), 32'd1);
        chk("unk_pre_pc", inst_pc_o, 32'h40);
        chk("unk_req", 32'(imem_req_o), 32'd0);
        step();
        sb_q.delete();
        setin(FS, 32'h44, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk); chk("unk_flushed", 32'(inst_valid_o), 32'd0); chk("unk_inst", inst_o, NOP); step();

        // Reset while WAIT: outputs clear at once; stale rvalid afterwards ignored.
        setin(FW, 32'h50, 1'b0, 1'b0, 32'h0, 1'b1); step();
        setin(FW, 32'h50, 1'b1, 1'b0, 32'h0, 1'b1); step();
        setin(FW, 32'h54, 1'b1, 1'b0, 32'h0, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_outs("rst_wait", 1'b0, 32'h0, 1'b0, 1'b0, NOP, 32'h0);
        step();
        rst_n = 1'b1;
        setin(FS, 32'h54, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b1);
        @(negedge clk); step();
        setin(FS, 32'h54, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk); chk_outs("rst_stale", 1'b0, 32'h0, 1'b0, 1'b0, NOP, 32'h0); step();

        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
